// File: rtl/dma_desc_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hansen_dma_pkg: shared encodings for the DMA descriptor sequencer  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package hansen_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PROG  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_e;

  // DMA controller config register offsets
  localparam logic [31:0] DMA_SRC_OFS  = 32'h0;
  localparam logic [31:0] DMA_DST_OFS  = 32'h4;
  localparam logic [31:0] DMA_LEN_OFS  = 32'h8;
  localparam logic [31:0] DMA_CTRL_OFS = 32'hC;

  // Descriptor word indices (byte offset = index * 4)
  localparam logic [1:0] DESC_SRC_IDX  = 2'd0;
  localparam logic [1:0] DESC_DST_IDX  = 2'd1;
  localparam logic [1:0] DESC_LEN_IDX  = 2'd2;
  localparam logic [1:0] DESC_NEXT_IDX = 2'd3;

  // Sequencer register offsets, decoded on s_addr[3:0]
  localparam logic [3:0] SEQ_HEAD_OFS = 4'h0;
  localparam logic [3:0] SEQ_CTRL_OFS = 4'h4;

endpackage
`default_nettype wire

// File: rtl/dma_desc_sequencer_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dma_desc_fetch: 4-word req/ack descriptor reader with capture regs |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dma_desc_fetch
  import hansen_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] base_i,
  input  logic        stop_i,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        ack_i,
  input  logic [31:0] data_i,
  output logic        ack_o,
  output logic        last_o,
  output logic [31:0] src_o,
  output logic [31:0] dst_o,
  output logic [31:0] len_o,
  output logic [31:0] next_o
);

  logic             req_q;
  logic [31:0]      addr_q;
  logic [1:0]       idx_q;
  logic [3:0][31:0] word_q;

  assign ack_o  = req_q & ack_i;
  assign last_o = ack_o & (idx_q == DESC_NEXT_IDX);
  assign req_o  = req_q;
  assign addr_o = addr_q;
  assign src_o  = word_q[DESC_SRC_IDX];
  assign dst_o  = word_q[DESC_DST_IDX];
  assign len_o  = word_q[DESC_LEN_IDX];
  assign next_o = word_q[DESC_NEXT_IDX];

  // A stop only takes effect on an ack edge so a request is never withdrawn
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q  <= 1'b0;
      addr_q <= 32'd0;
      idx_q  <= 2'd0;
      word_q <= '0;
    end else if (start_i) begin
      req_q  <= 1'b1;
      addr_q <= {base_i[31:2], 2'b00};
      idx_q  <= 2'd0;
    end else if (ack_o) begin
      word_q[idx_q] <= data_i;
      idx_q         <= idx_q + 2'd1;
      addr_q        <= addr_q + 32'd4;
      if (stop_i || last_o) begin
        req_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma_desc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dma_desc_sequencer: walks a descriptor list and programs the DMA   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dma_desc_sequencer
  import hansen_dma_pkg::*;
#(
  parameter int MAX_DESC     = 256,
  parameter int WAIT_TIMEOUT = 65535,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      s_addr,
  input  logic [31:0]      s_wdata,
  input  logic             s_we,
  output logic             rd_req,
  output logic [31:0]      rd_addr,
  input  logic             rd_ack,
  input  logic [31:0]      rd_data,
  output logic [31:0]      dma_cfg_addr,
  output logic [31:0]      dma_cfg_wdata,
  output logic             dma_cfg_we,
  input  logic             dma_irq_done,
  output logic             busy,
  output logic [CNT_W-1:0] desc_count,
  output logic             irq_chain_done,
  output logic             err,
  output logic             aborted
);

  localparam int               TMR_W   = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  seq_state_e       state_q;
  logic [31:0]      head_q;
  logic             abort_q;
  logic [1:0]       prog_idx_q;
  logic [TMR_W-1:0] tmr_q;
  logic             busy_q, err_q, aborted_q, irq_q, cfg_we_q;
  logic [31:0]      cfg_addr_q, cfg_wdata_q;
  logic [CNT_W-1:0] cnt_q;

  logic        w_ctrl_wr, w_head_wr, w_start, w_abort_req;
  logic        w_fetch_start, w_fetch_ack, w_fetch_last, w_next_ok;
  logic [31:0] w_fetch_base, w_src, w_dst, w_len, w_next;
  logic [1:0]  w_prog_nxt;
  logic [31:0] w_prog_addr, w_prog_data;
  logic        w_unused_addr;

  assign w_ctrl_wr     = s_we && (s_addr[3:0] == SEQ_CTRL_OFS);
  assign w_head_wr     = s_we && (s_addr[3:0] == SEQ_HEAD_OFS);
  assign w_start       = w_ctrl_wr && s_wdata[0] && (state_q == ST_IDLE);
  assign w_abort_req   = abort_q || (w_ctrl_wr && s_wdata[1] && busy_q);
  assign w_next_ok     = (w_next != 32'd0) && (cnt_q != CNT_W'(MAX_DESC));
  assign w_fetch_start = w_start || ((state_q == ST_NEXT) && !w_abort_req && w_next_ok);
  assign w_fetch_base  = (state_q == ST_IDLE) ? head_q : w_next;
  assign w_prog_nxt    = prog_idx_q + 2'd1;
  assign w_unused_addr = ^s_addr[31:4];

  dma_desc_fetch u_fetch (
    .clk     (clk),
    .reset   (reset),
    .start_i (w_fetch_start),
    .base_i  (w_fetch_base),
    .stop_i  (w_abort_req),
    .req_o   (rd_req),
    .addr_o  (rd_addr),
    .ack_i   (rd_ack),
    .data_i  (rd_data),
    .ack_o   (w_fetch_ack),
    .last_o  (w_fetch_last),
    .src_o   (w_src),
    .dst_o   (w_dst),
    .len_o   (w_len),
    .next_o  (w_next)
  );

  always_comb begin
    w_prog_addr = DMA_SRC_OFS;
    w_prog_data = w_src;
    case (w_prog_nxt)
      2'd1:    begin w_prog_addr = DMA_DST_OFS;  w_prog_data = w_dst; end
      2'd2:    begin w_prog_addr = DMA_LEN_OFS;  w_prog_data = w_len; end
      2'd3:    begin w_prog_addr = DMA_CTRL_OFS; w_prog_data = 32'd1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      head_q      <= 32'd0;
      abort_q     <= 1'b0;
      prog_idx_q  <= 2'd0;
      tmr_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      aborted_q   <= 1'b0;
      irq_q       <= 1'b0;
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= 32'd0;
      cfg_wdata_q <= 32'd0;
      cnt_q       <= '0;
    end else begin
      irq_q <= 1'b0;
      if (w_head_wr && (state_q == ST_IDLE)) begin
        head_q <= s_wdata;
      end
      // Abort is latched here and overridden below wherever the chain ends
      if (w_abort_req) begin
        abort_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (w_start) begin
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            state_q   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (w_fetch_ack && w_abort_req) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            abort_q   <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (w_fetch_last) begin
            if (w_len == 32'd0) begin
              state_q <= ST_NEXT;
            end else begin
              cfg_we_q    <= 1'b1;
              cfg_addr_q  <= DMA_SRC_OFS;
              cfg_wdata_q <= w_src;
              prog_idx_q  <= 2'd0;
              state_q     <= ST_PROG;
            end
          end
        end
        ST_PROG: begin
          if (prog_idx_q == 2'd3) begin
            cfg_we_q <= 1'b0;
            tmr_q    <= '0;
            state_q  <= ST_WAIT;
          end else begin
            prog_idx_q  <= w_prog_nxt;
            cfg_addr_q  <= w_prog_addr;
            cfg_wdata_q <= w_prog_data;
          end
        end
        ST_WAIT: begin
          if (dma_irq_done) begin
            if (cnt_q != CNT_MAX) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            state_q <= ST_NEXT;
          end else if (tmr_q == TMR_W'(WAIT_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_NEXT: begin
          if (w_abort_req) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            abort_q   <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (w_next == 32'd0) begin
            irq_q   <= 1'b1;
            state_q <= ST_DONE;
          end else if (!w_next_ok) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dma_cfg_addr   = cfg_addr_q;
  assign dma_cfg_wdata  = cfg_wdata_q;
  assign dma_cfg_we     = cfg_we_q;
  assign busy           = busy_q;
  assign desc_count     = cnt_q;
  assign irq_chain_done = irq_q;
  assign err            = err_q;
  assign aborted        = aborted_q;

endmodule
`default_nettype wire
